inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage between Instruction_Memory and the ARM_CPU core.
- Owns the program counter and issues word fetches over a req/ack handshake; memory latency may be zero or more cycles.
- Presents fetched instructions to the core over a valid/ready handshake.
- Handles branch redirects from the core and computes the LEGv8 target as base + sign-extended word offset × 4.
- Discards any fetch that is still in flight when a redirect arrives.

Parameters:
- RESET_PC, 64'h0: PC value after reset. Bits [1:0] must be 00.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high with imem_addr stable until imem_ack.
- imem_addr  out  64  byte address of the requested instruction.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata is valid in the same cycle; may rise in the same cycle as imem_req.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst_out and inst_pc hold a valid instruction.
- inst_ready  in  1  core accepts the instruction this cycle.
- inst_out  out  32  instruction to the core.
- inst_pc  out  64  address of inst_out.
- redirect_valid  in  1  one-cycle redirect strobe from the core.
- redirect_base  in  64  PC of the branch instruction.
- redirect_offset  in  26  signed word offset; the core sign-extends the CB 19-bit field to 26 bits.

Behaviour:
- Reset (asynchronous) forces:
  - pc_q=RESET_PC, state=FETCH
  - inst_valid=0, inst_out=0, inst_pc=0
  - imem_req=0 during reset
- The first request goes out in the first cycle after RESET deasserts.
- States: FETCH (normal streaming) and DRAIN (a stale request is outstanding).
- imem_addr=pc_q in FETCH. In DRAIN, imem_addr holds the stale address.
- imem_req is high in DRAIN. In FETCH it is high when (!inst_valid || inst_ready).
- Once imem_req rises, it and imem_addr stay stable until imem_ack is sampled high, including under redirect.
- FETCH, ack, no redirect:
  - inst_out<=imem_rdata, inst_pc<=pc_q, inst_valid<=1
  - pc_q<=pc_q+PC_STEP (mod 2^64, wraps silently)
- FETCH, inst_valid && inst_ready, no ack: inst_valid<=0.
- With zero-latency memory and inst_ready held high, throughput is one instruction per cycle.
- Redirect target: redirect_base + {{36{off[25]}}, off, 2'b00}, 64-bit modular add.
- On any redirect, inst_valid<=0 next cycle. If inst_valid && inst_ready in the redirect cycle, that transfer still counts as completed.
- FETCH + redirect + ack in the same cycle: the acked data is dropped, pc_q<=target, stay in FETCH.
- FETCH + redirect while imem_req high and no ack: pc_q<=target, go to DRAIN.
- FETCH + redirect while imem_req low: pc_q<=target, stay in FETCH.
- DRAIN + ack: data is dropped, go to FETCH. The new request at pc_q starts the next cycle.
- DRAIN + redirect: pc_q<=newest target (last redirect wins).
- DRAIN + redirect + ack in the same cycle: pc_q<=target, go to FETCH.
- imem_ack while imem_req is low is ignored.
- Output stall: inst_out and inst_pc hold while inst_valid && !inst_ready. No further fetch is issued.
- Reset mid-request: the outstanding request is abandoned. The memory must tolerate imem_req dropping.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetched [31:0]: counts completed core transfers (inst_valid && inst_ready).
  - perf_discarded [31:0]: counts acks dropped because of a redirect.
- Both counters reset to 0, wrap at 2^32, and increment in the same cycle as the event.
- When undefined, the ports and logic do not exist. Fetch behaviour is identical either way.

Test Plan:
- Reset, zero-latency memory, inst_ready=1 -> inst_pc sequence 0,4,8,12 on consecutive cycles; the first inst_valid appears 1 cycle after RESET falls.
- Memory with 3-cycle latency -> imem_addr=0 is held for 3 cycles, then inst_valid with inst_pc=0; the next request addr=4 follows.
- inst_ready=0 for 5 cycles with inst_valid=1 at pc=8 -> inst_out/inst_pc hold, imem_req=0, no pc advance; resume at pc=12.
- Redirect base=64'h20, offset=26'h3FFFFFE (-2) during a 3-cycle request to addr 0x10 -> DRAIN; the 0x10 data is dropped (perf_discarded=1); the next fetch is at 0x18.
- Redirect base=0x100, offset=5 in the same cycle as an ack -> that data is dropped; the next inst_pc=0x114, with no DRAIN entry.
- Assert RESET during a WAIT for 2 cycles -> outputs return to reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, core valid/ready and redirect strobe.
// The fetch unit uses the master modport; memory/core side uses slave.
interface inst_fetch_unit_if;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [63:0] inst_pc;
   logic        redirect_valid;
   logic [63:0] redirect_base;
   logic [25:0] redirect_offset;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output inst_valid,
      input  inst_ready,
      output inst_out,
      output inst_pc,
      input  redirect_valid,
      input  redirect_base,
      input  redirect_offset
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  inst_valid,
      output inst_ready,
      input  inst_out,
      input  inst_pc,
      output redirect_valid,
      output redirect_base,
      output redirect_offset
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, delivers over valid/ready, handles
// branch redirects. Define FETCH_PERF_EN to add perf_fetched/perf_discarded counters.
module inst_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [63:0] PC_STEP  = 64'd4
) (
   input  logic                CLOCK,
   input  logic                RESET,
   inst_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]         perf_fetched,
   output logic [31:0]         perf_discarded
`endif
);

   typedef enum logic [0:0] {StFetch, StDrain} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] stale_addr_q, stale_addr_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_out_q, inst_out_d;
   logic [63:0] inst_pc_q, inst_pc_d;

   logic [63:0] redirect_target;
   logic        req_raw;
   logic        ack_eff;
   logic        xfer;

   always_comb begin
      redirect_target = bus.redirect_base +
                        {{36{bus.redirect_offset[25]}}, bus.redirect_offset, 2'b00};
      // A request is only launched when the output slot is free or being emptied this cycle.
      req_raw         = (state_q == StDrain) || !inst_valid_q || bus.inst_ready;
      ack_eff         = req_raw && bus.imem_ack;
      xfer            = inst_valid_q && bus.inst_ready;

      state_d      = state_q;
      pc_d         = pc_q;
      stale_addr_d = stale_addr_q;
      inst_valid_d = inst_valid_q;
      inst_out_d   = inst_out_q;
      inst_pc_d    = inst_pc_q;

      unique case (state_q)
         StFetch: begin
            if (bus.redirect_valid) begin
               pc_d         = redirect_target;
               inst_valid_d = 1'b0;
               if (req_raw && !bus.imem_ack) begin
                  state_d      = StDrain;
                  stale_addr_d = pc_q;
               end
            end else if (ack_eff) begin
               inst_out_d   = bus.imem_rdata;
               inst_pc_d    = pc_q;
               inst_valid_d = 1'b1;
               pc_d         = pc_q + PC_STEP;
            end else if (xfer) begin
               inst_valid_d = 1'b0;
            end
         end
         StDrain: begin
            if (bus.redirect_valid) begin
               pc_d         = redirect_target;
               inst_valid_d = 1'b0;
            end else if (xfer) begin
               inst_valid_d = 1'b0;
            end
            if (ack_eff) begin
               state_d = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         stale_addr_q <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_out_q   <= 32'h0;
         inst_pc_q    <= 64'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         stale_addr_q <= stale_addr_d;
         inst_valid_q <= inst_valid_d;
         inst_out_q   <= inst_out_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   // The request is suppressed while reset is asserted so an in-flight fetch is abandoned at once.
   assign bus.imem_req   = req_raw && !RESET;
   assign bus.imem_addr  = (state_q == StDrain) ? stale_addr_q : pc_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst_out   = inst_out_q;
   assign bus.inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] discarded_q, discarded_d;

   always_comb begin
      fetched_d   = fetched_q + {31'h0, xfer};
      discarded_d = discarded_q +
                    {31'h0, ack_eff && (bus.redirect_valid || (state_q == StDrain))};
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         fetched_q   <= 32'h0;
         discarded_q <= 32'h0;
      end else begin
         fetched_q   <= fetched_d;
         discarded_q <= discarded_d;
      end
   end

   assign perf_fetched   = fetched_q;
   assign perf_discarded = discarded_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized run checked
// against a PC-stream reference model and a latency-programmable memory model.
module tb_inst_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inst_fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_discarded;
`endif

   inst_fetch_unit #(
      .RESET_PC (64'h0),
      .PC_STEP  (64'd4)
   ) dut (
      .CLOCK (clk),
      .RESET (rst),
      .bus   (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_discarded (perf_discarded)
`endif
   );

   int vectors = 0;
   int miscompares = 0;

   // Memory model: ack arrives on the lat-th cycle a request has been held (lat=1 -> same cycle).
   int   lat = 1;
   int   wait_cnt = 0;
   logic prev_req = 1'b0;
   logic prev_ack = 1'b0;

   logic        obs_req, obs_valid;
   logic [63:0] obs_addr, obs_pc;
   logic [31:0] obs_out;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[33:2] ^ a[63:32] ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [63:0] br_target(input logic [63:0] base, input logic [25:0] off);
      logic signed [63:0] soff;
      soff = 64'(signed'(off));
      return base + soff * 4;
   endfunction

   task automatic cyc(input logic r, input logic rdy, input logic rv,
                      input logic [63:0] rb, input logic [25:0] ro);
      @(negedge clk);
      if (prev_req && !prev_ack) wait_cnt++;
      else wait_cnt = 0;
      rst                 = r;
      bus.inst_ready      = rdy;
      bus.redirect_valid  = rv;
      bus.redirect_base   = rb;
      bus.redirect_offset = ro;
      bus.imem_ack        = 1'b0;
      #1;
      bus.imem_ack   = bus.imem_req && (wait_cnt + 1 >= lat);
      bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
      #1;
      obs_req   = bus.imem_req;
      obs_addr  = bus.imem_addr;
      obs_valid = bus.inst_valid;
      obs_pc    = bus.inst_pc;
      obs_out   = bus.inst_out;
      prev_req  = bus.imem_req;
      prev_ack  = bus.imem_ack;
   endtask

   task automatic run(input logic rdy);
      cyc(1'b0, rdy, 1'b0, 64'h0, 26'h0);
   endtask

   task automatic test_reset;
      lat = 1;
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      vectors++;
      if ({obs_valid, obs_req, obs_out, obs_pc} !== {1'b0, 1'b0, 32'h0, 64'h0}) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b req=%b out=%h pc=%h want all zero",
                  obs_valid, obs_req, obs_out, obs_pc);
      end
`ifdef FETCH_PERF_EN
      vectors++;
      if ({perf_fetched, perf_discarded} !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetched, perf_discarded);
      end
`endif
   endtask

   task automatic test_stream;
      lat = 1;
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      run(1'b1);
      vectors++;
      if ({obs_req, obs_addr, obs_valid} !== {1'b1, 64'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL stream_first_req: got req=%b addr=%h v=%b want 1/0/0",
                  obs_req, obs_addr, obs_valid);
      end
      for (int i = 0; i < 4; i++) begin
         run(1'b1);
         vectors++;
         if ({obs_valid, obs_pc, obs_out} !== {1'b1, 64'(i * 4), mem_word(64'(i * 4))}) begin
            miscompares++;
            $display("FAIL stream_pc[%0d]: got v=%b pc=%h out=%h want pc=%h", i,
                     obs_valid, obs_pc, obs_out, 64'(i * 4));
         end
      end
   endtask

   task automatic test_latency;
      lat = 3;
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      for (int i = 0; i < 3; i++) begin
         run(1'b1);
         vectors++;
         if ({obs_req, obs_addr, obs_valid} !== {1'b1, 64'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL latency_hold[%0d]: got req=%b addr=%h v=%b want 1/0/0", i,
                     obs_req, obs_addr, obs_valid);
         end
      end
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_pc, obs_req, obs_addr} !== {1'b1, 64'h0, 1'b1, 64'h4}) begin
         miscompares++;
         $display("FAIL latency_done: got v=%b pc=%h req=%b addr=%h want 1/0/1/4",
                  obs_valid, obs_pc, obs_req, obs_addr);
      end
   endtask

   task automatic test_stall;
      lat = 1;
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      run(1'b1);
      run(1'b1);
      run(1'b1);
      for (int i = 0; i < 5; i++) begin
         run(1'b0);
         vectors++;
         if ({obs_valid, obs_pc, obs_out, obs_req} !== {1'b1, 64'h8, mem_word(64'h8), 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got v=%b pc=%h out=%h req=%b want 1/8/%h/0", i,
                     obs_valid, obs_pc, obs_out, obs_req, mem_word(64'h8));
         end
      end
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_pc, obs_req, obs_addr} !== {1'b1, 64'h8, 1'b1, 64'hC}) begin
         miscompares++;
         $display("FAIL stall_release: got v=%b pc=%h req=%b addr=%h want 1/8/1/c",
                  obs_valid, obs_pc, obs_req, obs_addr);
      end
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_pc} !== {1'b1, 64'hC}) begin
         miscompares++;
         $display("FAIL stall_resume: got v=%b pc=%h want 1/c", obs_valid, obs_pc);
      end
   endtask

   task automatic test_redirect_drain;
      lat = 1;
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      run(1'b1);
      run(1'b1);
      run(1'b1);
      run(1'b1);
      lat = 3;
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_pc, obs_req, obs_addr} !== {1'b1, 64'hC, 1'b1, 64'h10}) begin
         miscompares++;
         $display("FAIL drain_setup: got v=%b pc=%h req=%b addr=%h want 1/c/1/10",
                  obs_valid, obs_pc, obs_req, obs_addr);
      end
      cyc(1'b0, 1'b1, 1'b1, 64'h20, 26'h3FFFFFE);
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_req, obs_addr} !== {1'b0, 1'b1, 64'h10}) begin
         miscompares++;
         $display("FAIL drain_stale_addr: got v=%b req=%b addr=%h want 0/1/10",
                  obs_valid, obs_req, obs_addr);
      end
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_req, obs_addr} !== {1'b0, 1'b1, 64'h18}) begin
         miscompares++;
         $display("FAIL drain_new_addr: got v=%b req=%b addr=%h want 0/1/18",
                  obs_valid, obs_req, obs_addr);
      end
`ifdef FETCH_PERF_EN
      vectors++;
      if ({perf_fetched, perf_discarded} !== {32'd4, 32'd1}) begin
         miscompares++;
         $display("FAIL drain_perf: got %0d/%0d want 4/1", perf_fetched, perf_discarded);
      end
`endif
      run(1'b1);
      run(1'b1);
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_pc, obs_out} !== {1'b1, 64'h18, mem_word(64'h18)}) begin
         miscompares++;
         $display("FAIL drain_target: got v=%b pc=%h out=%h want pc=18",
                  obs_valid, obs_pc, obs_out);
      end
   endtask

   task automatic test_redirect_ack;
      lat = 1;
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      run(1'b1);
      cyc(1'b0, 1'b1, 1'b1, 64'h100, 26'd5);
      vectors++;
      if ({obs_valid, obs_pc} !== {1'b1, 64'h0}) begin
         miscompares++;
         $display("FAIL redir_ack_xfer: got v=%b pc=%h want 1/0", obs_valid, obs_pc);
      end
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_req, obs_addr} !== {1'b0, 1'b1, 64'h114}) begin
         miscompares++;
         $display("FAIL redir_ack_addr: got v=%b req=%b addr=%h want 0/1/114",
                  obs_valid, obs_req, obs_addr);
      end
`ifdef FETCH_PERF_EN
      vectors++;
      if ({perf_fetched, perf_discarded} !== {32'd1, 32'd1}) begin
         miscompares++;
         $display("FAIL redir_ack_perf: got %0d/%0d want 1/1", perf_fetched, perf_discarded);
      end
`endif
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_pc, obs_out} !== {1'b1, 64'h114, mem_word(64'h114)}) begin
         miscompares++;
         $display("FAIL redir_ack_target: got v=%b pc=%h out=%h want pc=114",
                  obs_valid, obs_pc, obs_out);
      end
   endtask

   task automatic test_reset_mid;
      lat = 1;
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      run(1'b1);
      run(1'b1);
      lat = 4;
      run(1'b1);
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_req, obs_addr, obs_pc} !== {1'b0, 1'b1, 64'h8, 64'h4}) begin
         miscompares++;
         $display("FAIL rstmid_wait: got v=%b req=%b addr=%h pc=%h want 0/1/8/4",
                  obs_valid, obs_req, obs_addr, obs_pc);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
         vectors++;
         if ({obs_valid, obs_req, obs_out, obs_pc} !== {1'b0, 1'b0, 32'h0, 64'h0}) begin
            miscompares++;
            $display("FAIL rstmid_outputs[%0d]: got v=%b req=%b out=%h pc=%h want zero", i,
                     obs_valid, obs_req, obs_out, obs_pc);
         end
      end
      lat = 1;
      run(1'b1);
      vectors++;
      if ({obs_req, obs_addr} !== {1'b1, 64'h0}) begin
         miscompares++;
         $display("FAIL rstmid_restart: got req=%b addr=%h want 1/0", obs_req, obs_addr);
      end
      run(1'b1);
      vectors++;
      if ({obs_valid, obs_pc} !== {1'b1, 64'h0}) begin
         miscompares++;
         $display("FAIL rstmid_first: got v=%b pc=%h want 1/0", obs_valid, obs_pc);
      end
   endtask

   task automatic test_random;
      logic [63:0] exp_pc;
      logic [63:0] rb;
      logic [25:0] ro;
      logic        rdy, rv;
      logic        h_req, h_ack;
      logic [63:0] h_addr;
      int          ntransfers;
      lat = 1;
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 26'h0);
      exp_pc     = 64'h0;
      ntransfers = 0;
      for (int i = 0; i < 3000; i++) begin
         rdy = ($urandom_range(0, 3) != 0);
         rv  = (i == 0) || ($urandom_range(0, 15) == 0);
         rb  = {$urandom, $urandom} & ~64'h3;
         ro  = 26'($urandom);
         if (i == 0) begin
            rb = 64'hFFFF_FFFF_FFFF_FFF4;
            ro = 26'h0;
         end
         lat    = $urandom_range(1, 3);
         h_req  = prev_req;
         h_ack  = prev_ack;
         h_addr = obs_addr;
         cyc(1'b0, rdy, rv, rb, ro);
         if (i > 0 && h_req && !h_ack) begin
            vectors++;
            if ({obs_req, obs_addr} !== {1'b1, h_addr}) begin
               miscompares++;
               $display("FAIL rand_req_stable[%0d]: got req=%b addr=%h want 1/%h", i,
                        obs_req, obs_addr, h_addr);
            end
         end
         if (obs_valid && rdy) begin
            vectors++;
            if ({obs_pc, obs_out} !== {exp_pc, mem_word(exp_pc)}) begin
               miscompares++;
               $display("FAIL rand_xfer[%0d]: got pc=%h out=%h want pc=%h out=%h", i,
                        obs_pc, obs_out, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 64'd4;
            ntransfers++;
         end
         if (rv) exp_pc = br_target(rb, ro);
      end
      vectors++;
      if (ntransfers < 500) begin
         miscompares++;
         $display("FAIL rand_progress: got %0d transfers want >= 500", ntransfers);
      end
`ifdef FETCH_PERF_EN
      vectors++;
      if (perf_fetched !== 32'(ntransfers)) begin
         miscompares++;
         $display("FAIL rand_perf_fetched: got %0d want %0d", perf_fetched, ntransfers);
      end
`endif
   endtask

   initial begin
      bus.imem_ack        = 1'b0;
      bus.imem_rdata      = 32'h0;
      bus.inst_ready      = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_base   = 64'h0;
      bus.redirect_offset = 26'h0;
      test_reset();
      test_stream();
      test_latency();
      test_stall();
      test_redirect_drain();
      test_redirect_ack();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
